// File: rtl/decode_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_buffer
// Description : RV32IM fetch buffer with head decode and a per-register
//               scoreboard; issues one operand-ready instruction per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_buffer #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_instr,
    output logic [31:0] issue_pc,
    output logic [1:0]  issue_fu,
    output logic [4:0]  issue_rd,
    output logic        issue_wen,
    output logic        issue_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_cw    = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    // Bit 0 is never tracked, so x0 can never raise a hazard or be marked busy.
    localparam logic [31:0] c_sb_mask =
        ((NUM_REGS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_REGS) - 32'd1)) & 32'hFFFF_FFFE;

    localparam logic [6:0] c_op_lui     = 7'b0110111;
    localparam logic [6:0] c_op_auipc   = 7'b0010111;
    localparam logic [6:0] c_op_jal     = 7'b1101111;
    localparam logic [6:0] c_op_jalr    = 7'b1100111;
    localparam logic [6:0] c_op_branch  = 7'b1100011;
    localparam logic [6:0] c_op_load    = 7'b0000011;
    localparam logic [6:0] c_op_store   = 7'b0100011;
    localparam logic [6:0] c_op_immed   = 7'b0010011;
    localparam logic [6:0] c_op_regreg  = 7'b0110011;
    localparam logic [6:0] c_op_system  = 7'b1110011;
    localparam logic [6:0] c_op_miscmem = 7'b0001111;

    localparam logic [1:0] c_fu_arith = 2'd0;
    localparam logic [1:0] c_fu_mul   = 2'd1;
    localparam logic [1:0] c_fu_div   = 2'd2;
    localparam logic [1:0] c_fu_lsu   = 2'd3;

    logic [31:0]      r_instr_mem [DEPTH];
    logic [31:0]      r_pc_mem    [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_cw-1:0]  r_count;
    logic [31:0]      r_sb;

    logic        w_empty;
    logic [31:0] w_head;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_known;
    logic        w_wen_raw;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_is_lsu;
    logic        w_is_m;
    logic        w_hazard;
    logic        w_enq;
    logic        w_deq;
    logic [31:0] w_sb_set;
    logic [31:0] w_sb_clr;

    // An empty buffer presents an all-zero word, which decodes as a harmless ARITH.
    assign w_empty = (r_count == '0);
    assign w_head  = w_empty ? 32'd0 : r_instr_mem[r_rptr];
    assign w_opc   = w_head[6:0];
    assign w_f3    = w_head[14:12];
    assign w_f7    = w_head[31:25];
    assign w_rs1   = w_head[19:15];
    assign w_rs2   = w_head[24:20];

    always_comb begin
        w_known    = 1'b1;
        w_wen_raw  = 1'b0;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        w_is_lsu   = 1'b0;
        case (w_opc)
            c_op_lui, c_op_auipc, c_op_jal: begin
                w_wen_raw  = 1'b1;
                w_rs1_used = 1'b0;
            end
            c_op_jalr, c_op_immed: w_wen_raw = 1'b1;
            c_op_branch:           w_rs2_used = 1'b1;
            c_op_load: begin
                w_wen_raw = 1'b1;
                w_is_lsu  = 1'b1;
            end
            c_op_store: begin
                w_rs2_used = 1'b1;
                w_is_lsu   = 1'b1;
            end
            c_op_regreg: begin
                w_wen_raw  = 1'b1;
                w_rs2_used = 1'b1;
            end
            c_op_system: begin
                w_wen_raw  = (w_f3 != 3'b000) && (w_f3 != 3'b100);
                w_rs1_used = !w_f3[2];
            end
            c_op_miscmem, 7'b0000000: ;
            default: w_known = 1'b0;
        endcase
    end

    assign w_is_m        = (w_opc == c_op_regreg) && (w_f7 == 7'b0000001);
    assign issue_illegal = !w_known
                         || ((w_opc == c_op_regreg) && w_f7[0] && (w_f7 != 7'b0000001))
                         || (w_is_m && !ENABLE_M);
    assign issue_wen     = w_wen_raw && !issue_illegal;
    assign issue_fu      = issue_illegal ? c_fu_arith :
                           w_is_lsu      ? c_fu_lsu   :
                           w_is_m        ? (w_f3[2] ? c_fu_div : c_fu_mul) :
                                           c_fu_arith;
    assign issue_rd      = w_head[11:7];
    assign issue_instr   = w_head;
    assign issue_pc      = w_empty ? 32'd0 : r_pc_mem[r_rptr];

    assign w_hazard = !issue_illegal
                    && ((w_rs1_used && r_sb[w_rs1])
                     || (w_rs2_used && r_sb[w_rs2])
                     || (issue_wen  && r_sb[issue_rd]));

    assign fetch_ready = (r_count < c_depth);
    assign issue_valid = !w_empty && !w_hazard && !flush;
    assign w_enq       = fetch_valid && fetch_ready && !flush;
    assign w_deq       = issue_valid && issue_ready;

    assign w_sb_clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign w_sb_set = (w_deq && issue_wen) ? (32'd1 << issue_rd) : 32'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush leaves the scoreboard alone: issued operations still write back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_sb <= '0;
        else     r_sb <= ((r_sb & ~w_sb_clr) | w_sb_set) & c_sb_mask;
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_instr_mem[r_wptr] <= fetch_instr;
            r_pc_mem[r_wptr]    <= fetch_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_buffer
// Description : Directed vector table plus hand-written hazard/flush sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_buffer;

    logic        CLK, RST, flush, wb_valid;
    logic [4:0]  wb_rd;
    logic        fetch_valid, issue_ready, fetch_ready, issue_valid;
    logic [31:0] fetch_instr, fetch_pc, issue_instr, issue_pc;
    logic [1:0]  issue_fu;
    logic [4:0]  issue_rd;
    logic        issue_wen, issue_illegal;

    logic        m0_fetch_valid, m0_issue_ready, m0_fetch_ready, m0_issue_valid;
    logic [31:0] m0_fetch_instr, m0_issue_instr, m0_issue_pc;
    logic [1:0]  m0_issue_fu;
    logic [4:0]  m0_issue_rd;
    logic        m0_issue_wen, m0_issue_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    decode_issue_buffer #(.DEPTH(4), .NUM_REGS(32), .ENABLE_M(1'b1)) u_dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_fu(issue_fu),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_illegal(issue_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    decode_issue_buffer #(.DEPTH(4), .NUM_REGS(32), .ENABLE_M(1'b0)) u_dut_nom (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fetch_valid(m0_fetch_valid), .fetch_instr(m0_fetch_instr), .fetch_pc(32'h0000_0040),
        .fetch_ready(m0_fetch_ready), .issue_valid(m0_issue_valid), .issue_ready(m0_issue_ready),
        .issue_instr(m0_issue_instr), .issue_pc(m0_issue_pc), .issue_fu(m0_issue_fu),
        .issue_rd(m0_issue_rd), .issue_wen(m0_issue_wen), .issue_illegal(m0_issue_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fu;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        flush = 0; fetch_valid = 0; fetch_instr = 0; fetch_pc = 0; issue_ready = 0;
        wb_valid = 0; wb_rd = 0;
        m0_fetch_valid = 0; m0_fetch_instr = 0; m0_issue_ready = 0;
        RST = 1'b1;
        #3;
        RST = 1'b0;
        tick();
    endtask

    vec_t        vecs [12];
    logic [31:0] q [$];

    initial begin
        vecs[0]  = '{32'h0050_0093, 2'd0, 5'd1, 1'b1, 1'b0}; // ADDI x1,x0,5
        vecs[1]  = '{32'h0220_81B3, 2'd1, 5'd3, 1'b1, 1'b0}; // MUL x3,x1,x2
        vecs[2]  = '{32'h0220_C1B3, 2'd2, 5'd3, 1'b1, 1'b0}; // DIV x3,x1,x2
        vecs[3]  = '{32'h0000_A283, 2'd3, 5'd5, 1'b1, 1'b0}; // LW x5,0(x1)
        vecs[4]  = '{32'h0020_A223, 2'd3, 5'd4, 1'b0, 1'b0}; // SW x2,4(x1)
        vecs[5]  = '{32'h0020_8063, 2'd0, 5'd0, 1'b0, 1'b0}; // BEQ x1,x2,0
        vecs[6]  = '{32'h0000_007F, 2'd0, 5'd0, 1'b0, 1'b1}; // unknown opcode
        vecs[7]  = '{32'h3000_9373, 2'd0, 5'd6, 1'b1, 1'b0}; // CSRRW x6
        vecs[8]  = '{32'h0000_0073, 2'd0, 5'd0, 1'b0, 1'b0}; // ECALL
        vecs[9]  = '{32'h0620_81B3, 2'd0, 5'd3, 1'b0, 1'b1}; // funct7=0000011
        vecs[10] = '{32'h1234_53B7, 2'd0, 5'd7, 1'b1, 1'b0}; // LUI x7
        vecs[11] = '{32'h4020_8433, 2'd0, 5'd8, 1'b1, 1'b0}; // SUB x8,x1,x2

        do_reset();
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_issue_instr", issue_instr, 32'd0);
        chk("rst_issue_pc",    issue_pc, 32'd0);
        chk("rst_issue_fu",    32'(issue_fu), 32'd0);
        chk("rst_issue_wen",   32'(issue_wen), 32'd0);
        chk("rst_issue_ill",   32'(issue_illegal), 32'd0);

        // Decode table: enqueue, check head one cycle later, issue, write back rd.
        for (int i = 0; i < 12; i++) begin
            fetch_valid = 1; fetch_instr = vecs[i].instr; fetch_pc = 32'h1000 + 32'(i * 4);
            issue_ready = 0;
            tick();
            fetch_valid = 0; issue_ready = 1;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), issue_instr, vecs[i].instr);
            chk($sformatf("vec%0d_pc", i),    issue_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("vec%0d_fu", i),    32'(issue_fu), 32'(vecs[i].fu));
            chk($sformatf("vec%0d_rd", i),    32'(issue_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_wen", i),   32'(issue_wen), 32'(vecs[i].wen));
            chk($sformatf("vec%0d_ill", i),   32'(issue_illegal), 32'(vecs[i].ill));
            tick();
            issue_ready = 0; wb_valid = 1; wb_rd = vecs[i].rd;
            tick();
            wb_valid = 0;
        end

        // ADDI x1 marks x1 busy: a reader of x1 waits for its writeback.
        do_reset();
        issue_ready = 1; fetch_valid = 1; fetch_instr = 32'h0050_0093; fetch_pc = 32'h10;
        tick();
        fetch_instr = 32'h0000_8133; fetch_pc = 32'h14; // ADD x2,x1,x0
        #1;
        chk("addi_first_valid", 32'(issue_valid), 32'd1);
        tick();
        fetch_valid = 0;
        #1;
        chk("raw_x1_stall", 32'(issue_valid), 32'd0);
        tick();
        wb_valid = 1; wb_rd = 5'd1;
        tick();
        wb_valid = 0;
        #1;
        chk("raw_x1_release", 32'(issue_valid), 32'd1);
        tick();

        // Fill, full, concurrent enq/deq across pointer wrap, drain in order.
        do_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1; fetch_instr = NOP; fetch_pc = 32'h100 + 32'(i * 4);
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(fetch_ready), 32'd1);
            q.push_back(fetch_pc);
            tick();
        end
        fetch_valid = 0;
        #1;
        chk("full_ready_low", 32'(fetch_ready), 32'd0);
        fetch_valid = 1; fetch_pc = 32'h1FC; issue_ready = 1;
        #1;
        chk("full_no_bypass", 32'(fetch_ready), 32'd0);
        chk("full_head_pc", issue_pc, q[0]);
        tick();
        void'(q.pop_front());
        for (int k = 0; k < 6; k++) begin
            fetch_pc = 32'h200 + 32'(k * 4);
            #1;
            chk($sformatf("steady%0d_ready", k), 32'(fetch_ready), 32'd1);
            chk($sformatf("steady%0d_pc", k), issue_pc, q[0]);
            q.push_back(fetch_pc);
            tick();
            void'(q.pop_front());
        end
        issue_ready = 0; fetch_pc = 32'h300;
        #1;
        chk("refill_ready", 32'(fetch_ready), 32'd1);
        q.push_back(fetch_pc);
        tick();
        fetch_valid = 0;
        #1;
        chk("refull_ready_low", 32'(fetch_ready), 32'd0);
        issue_ready = 1;
        for (int k = 0; k < 4 && q.size() > 0; k++) begin
            #1;
            chk($sformatf("drain%0d_valid", k), 32'(issue_valid), 32'd1);
            chk($sformatf("drain%0d_pc", k), issue_pc, q[0]);
            tick();
            void'(q.pop_front());
        end
        #1;
        chk("drained_empty", 32'(issue_valid), 32'd0);
        issue_ready = 0;

        // MUL x3 then dependent ADD x4,x3: release only the cycle after wb x3.
        do_reset();
        issue_ready = 1; fetch_valid = 1; fetch_instr = 32'h0220_81B3; fetch_pc = 32'h20;
        tick();
        fetch_instr = 32'h0001_8233; fetch_pc = 32'h24;
        #1;
        chk("mul_valid", 32'(issue_valid), 32'd1);
        chk("mul_fu", 32'(issue_fu), 32'd1);
        tick();
        fetch_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("add_stall%0d", k), 32'(issue_valid), 32'd0);
            tick();
        end
        wb_valid = 1; wb_rd = 5'd3;
        #1;
        chk("wb_same_cycle_stall", 32'(issue_valid), 32'd0);
        tick();
        wb_valid = 0;
        #1;
        chk("add_after_wb_valid", 32'(issue_valid), 32'd1);
        chk("add_after_wb_rd", 32'(issue_rd), 32'd4);
        tick();

        // Writeback and issue hit x5 in the same cycle: the set wins.
        do_reset();
        fetch_valid = 1; fetch_instr = 32'h0010_0293; fetch_pc = 32'h30;
        tick();
        fetch_instr = 32'h0002_8333; fetch_pc = 32'h34;
        issue_ready = 1; wb_valid = 1; wb_rd = 5'd5;
        #1;
        chk("addi_x5_valid", 32'(issue_valid), 32'd1);
        chk("addi_x5_rd", 32'(issue_rd), 32'd5);
        tick();
        fetch_valid = 0; wb_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("set_wins_stall%0d", k), 32'(issue_valid), 32'd0);
            tick();
        end
        wb_valid = 1; wb_rd = 5'd5;
        tick();
        wb_valid = 0;
        #1;
        chk("add_x6_release", 32'(issue_valid), 32'd1);
        chk("add_x6_rd", 32'(issue_rd), 32'd6);
        tick();

        // Illegal words never stall, even with their register fields busy.
        do_reset();
        issue_ready = 1; m0_issue_ready = 1;
        fetch_valid = 1; fetch_instr = 32'h0050_0093; fetch_pc = 32'h50;
        m0_fetch_valid = 1; m0_fetch_instr = 32'h0050_0093;
        tick();
        fetch_valid = 0; m0_fetch_valid = 0;
        tick();
        fetch_valid = 1; fetch_instr = 32'h0000_80FF; fetch_pc = 32'h54;
        m0_fetch_valid = 1; m0_fetch_instr = 32'h0220_C1B3;
        tick();
        fetch_valid = 0; m0_fetch_valid = 0;
        #1;
        chk("ill_valid", 32'(issue_valid), 32'd1);
        chk("ill_flag",  32'(issue_illegal), 32'd1);
        chk("ill_wen",   32'(issue_wen), 32'd0);
        chk("ill_fu",    32'(issue_fu), 32'd0);
        chk("nom_div_valid", 32'(m0_issue_valid), 32'd1);
        chk("nom_div_ill",   32'(m0_issue_illegal), 32'd1);
        chk("nom_div_wen",   32'(m0_issue_wen), 32'd0);
        chk("nom_div_fu",    32'(m0_issue_fu), 32'd0);
        tick();
        issue_ready = 0; m0_issue_ready = 0;

        // Flush empties the FIFO but keeps sb[7]; async reset clears everything.
        do_reset();
        issue_ready = 1; fetch_valid = 1; fetch_instr = 32'h0010_0393; fetch_pc = 32'h60;
        tick();
        fetch_valid = 0;
        #1;
        chk("addi_x7_valid", 32'(issue_valid), 32'd1);
        tick();
        issue_ready = 0;
        for (int k = 0; k < 3; k++) begin
            fetch_valid = 1; fetch_instr = NOP; fetch_pc = 32'h70 + 32'(k * 4);
            tick();
        end
        flush = 1; fetch_pc = 32'h7C;
        #1;
        chk("flush_valid_low", 32'(issue_valid), 32'd0);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd1);
        tick();
        flush = 0; fetch_valid = 0;
        #1;
        chk("post_flush_empty", 32'(issue_valid), 32'd0);
        issue_ready = 1; fetch_valid = 1; fetch_instr = 32'h0003_8433; fetch_pc = 32'h80;
        tick();
        fetch_valid = 0;
        #1;
        chk("sb7_kept_stall", 32'(issue_valid), 32'd0);
        chk("head_after_flush", issue_instr, 32'h0003_8433);
        issue_ready = 0;
        for (int k = 0; k < 3; k++) begin
            fetch_valid = 1; fetch_instr = NOP; fetch_pc = 32'h84 + 32'(k * 4);
            #1;
            chk($sformatf("postflush_fill%0d", k), 32'(fetch_ready), 32'd1);
            tick();
        end
        fetch_valid = 0;
        #1;
        chk("full_before_rst", 32'(fetch_ready), 32'd0);
        RST = 1;
        #2;
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        chk("async_rst_valid", 32'(issue_valid), 32'd0);
        RST = 0;
        tick();
        issue_ready = 1; fetch_valid = 1; fetch_instr = 32'h0003_8433; fetch_pc = 32'h90;
        tick();
        fetch_valid = 0;
        #1;
        chk("sb_cleared_by_rst", 32'(issue_valid), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
